uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, system clock frequency in MHz.
REQ-002 SHALL have parameter UART_RATE, default 115200, baud rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default PAR_NONE, one of PAR_NONE/PAR_EVEN/PAR_ODD.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, TX buffer depth in words; power of two, at least 2.
REQ-007 SHALL have port clk, input, 1 bit, single clock for all logic.
REQ-008 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port send_en, input, 1 bit, write strobe pushing send_data into the FIFO.
REQ-010 SHALL have port send_data, input, DATA_BITS bits, word to transmit.
REQ-011 SHALL have port send_full, output, 1 bit, FIFO full; writes are ignored while it is high.
REQ-012 SHALL have port send_busy, output, 1 bit, high while the FIFO is non-empty or a frame is in progress.
REQ-013 SHALL have port tx_pin, output, 1 bit, serial line, idle high.

Function
REQ-014 SHALL derive RATE_CNT = CLK_FRE*1000000/UART_RATE - 1 (integer division), so every bit period lasts exactly RATE_CNT+1 clk cycles.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL transmit each frame as: one start bit (0), DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop bits (1).
REQ-017 SHALL drive the parity bit to the XOR of the data bits for PAR_EVEN and to its inverse for PAR_ODD.
REQ-018 SHALL skip the PARITY state entirely for PAR_NONE, going DATA to STOP.
REQ-019 SHALL, in IDLE with the FIFO non-empty, pop one word into a shift register and enter START on the same edge.
REQ-020 SHALL drive tx_pin low from that same edge.
REQ-021 SHALL, for send_en sampled at edge N with the FIFO empty and the FSM in IDLE, pop at edge N+1, so tx_pin falls at edge N+1.
REQ-022 SHALL, at the end of the last stop bit with the FIFO non-empty, pop the next word and start the next start bit on the same edge, with no idle gap.
REQ-023 SHALL, at the end of the last stop bit with the FIFO empty, return to IDLE with tx_pin high.
REQ-024 SHALL accept a write only when send_en=1 and send_full=0.
REQ-025 SHALL ignore a write while full, even if a pop occurs in the same cycle.
REQ-026 SHALL, on a simultaneous write and pop while not full, perform both with the occupancy unchanged.
REQ-027 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with full/empty resolved by an extra pointer MSB.
REQ-028 SHALL drive send_full and send_busy combinationally from the registered state.
REQ-029 SHALL register tx_pin, with no glitches.

Reset
REQ-030 SHALL, on rst high, immediately force tx_pin=1, FSM=IDLE, all counters=0, FIFO pointers=0, send_full=0 and send_busy=0.
REQ-031 SHALL, on reset mid-frame, abort the frame and discard the FIFO contents; no partial frame resumes after reset.
REQ-032 SHALL deassert rst synchronously to clk, which is the integrator's responsibility; the block shall not add a synchroniser.

Structure
REQ-033 SHALL place the parity enum (PAR_NONE/PAR_EVEN/PAR_ODD) and the TX FSM state enum in shared package uart_pkg.
REQ-034 SHALL implement the FIFO as sub-module uart_fifo (parameters WIDTH, DEPTH; ports clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty), reusable by a future RX block.

Verification (CLK_FRE=50, UART_RATE=115200 -> 434 clk per bit unless noted)
REQ-035 SHALL cover default 8N1: write 0x55 -> tx_pin low at edge N+1, then bits 1,0,1,0,1,0,1,0 at 434-cycle spacing, then high; send_busy low 10*434 cycles after the start edge.
REQ-036 SHALL cover 7E2: write 0x41 -> 7 data bits 1,0,0,0,0,0,1, parity 0, two stop bits; frame length 11*434 cycles.
REQ-037 SHALL cover 8O1: write 0xFF -> parity bit 1.
REQ-038 SHALL cover 8O1: write 0x00 -> parity bit 1; write 0x01 -> parity bit 0.
REQ-039 SHALL cover FIFO_DEPTH=4 overflow: six back-to-back writes 0x01..0x06 -> send_full asserts and one write is dropped, then five back-to-back frames with no idle cycle between stop and start; 0x06 is never sent.
REQ-040 SHALL cover reset mid-frame: rst pulse during data bit 3 -> tx_pin=1 in the same cycle and send_busy=0; with no further writes, the line stays high for 20*434 cycles.
REQ-041 SHALL cover fast rate (CLK_FRE=1, UART_RATE=250000, RATE_CNT=3): check exact 4-cycle bit widths and a simultaneous write and pop at occupancy 1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity and transmitter state types
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - power-of-two FIFO with show-ahead read data
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - buffered UART transmitter with configurable frame format
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int      CLK_FRE    = 50,
    parameter int      UART_RATE  = 115200,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send_en,
    input  logic [DATA_BITS-1:0] send_data,
    output logic                 send_full,
    output logic                 send_busy,
    output logic                 tx_pin
);

    localparam int RATE_CNT = CLK_FRE * 1000000 / UART_RATE - 1;
    localparam int CW       = (RATE_CNT > 0) ? $clog2(RATE_CNT + 1) : 1;
    localparam logic [CW-1:0] RATE_LAST = CW'(RATE_CNT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_INV   = (PARITY == PAR_ODD);

    tx_state_t            state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 pop;
    logic                 baud_done;
    logic                 frame_end;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (send_en),
        .wr_data (send_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (send_full),
        .empty   (fifo_empty)
    );

    assign baud_done = (baud_cnt == RATE_LAST);
    assign frame_end = (state == ST_STOP) && baud_done && (bit_cnt == STOP_LAST);
    // Popping at the last stop edge chains frames with no idle gap.
    assign pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);
    assign send_busy = !fifo_empty || (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_pin   <= 1'b1;
        end else if (pop) begin
            shreg    <= fifo_data;
            par_bit  <= (^fifo_data) ^ PAR_INV;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_START;
            tx_pin   <= 1'b0;
        end else if (state == ST_IDLE) begin
            tx_pin <= 1'b1;
        end else if (!baud_done) begin
            baud_cnt <= baud_cnt + CNT_ONE;
        end else begin
            baud_cnt <= '0;
            case (state)
                ST_START: begin
                    tx_pin  <= shreg[0];
                    shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                    bit_cnt <= '0;
                    state   <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt != DATA_LAST) begin
                        tx_pin  <= shreg[0];
                        shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (PARITY != PAR_NONE) begin
                        tx_pin <= par_bit;
                        state  <= ST_PARITY;
                    end else begin
                        tx_pin  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end
                end
                ST_PARITY: begin
                    tx_pin  <= 1'b1;
                    bit_cnt <= '0;
                    state   <= ST_STOP;
                end
                ST_STOP: begin
                    if (bit_cnt != STOP_LAST) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else begin
                        bit_cnt <= '0;
                        tx_pin  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    tx_pin <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard bench for uart_tx_cfg across several frame formats
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int NCFG = 5;

    // 0: 8N1  1: 7E2  2: 8O1  3: 8N1 depth 4  4: 9O2 depth 4 at 4 clk per bit
    function automatic int c_clk(input int k);
        return (k == 4) ? 1 : 50;
    endfunction
    function automatic int c_baud(input int k);
        return (k == 4) ? 250000 : 115200;
    endfunction
    function automatic int c_bits(input int k);
        case (k)
            1:       return 7;
            4:       return 9;
            default: return 8;
        endcase
    endfunction
    function automatic parity_t c_par(input int k);
        case (k)
            1:       return PAR_EVEN;
            2, 4:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction
    function automatic int c_stop(input int k);
        return (k == 1 || k == 4) ? 2 : 1;
    endfunction
    function automatic int c_depth(input int k);
        return (k == 3 || k == 4) ? 4 : 16;
    endfunction
    function automatic int bit_cycles(input int k);
        return c_clk(k) * 1000000 / c_baud(k);
    endfunction
    function automatic int frame_len(input int k);
        return 1 + c_bits(k) + ((c_par(k) == PAR_NONE) ? 0 : 1) + c_stop(k);
    endfunction
    function automatic int frame_cycles(input int k);
        return frame_len(k) * bit_cycles(k);
    endfunction

    // Line levels of one frame, first bit on the wire in bit 0.
    function automatic logic [15:0] frame_of(input int k, input logic [8:0] d);
        logic [15:0] v;
        int ones;
        v = '1;
        v[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < c_bits(k); i++) begin
            v[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (c_par(k) == PAR_EVEN) v[1 + c_bits(k)] = ones[0];
        else if (c_par(k) == PAR_ODD) v[1 + c_bits(k)] = ~ones[0];
        return v;
    endfunction

    logic clk = 1'b0;
    logic [NCFG-1:0] rst;
    logic [NCFG-1:0] en;
    logic [8:0] sdata [NCFG];
    wire  [NCFG-1:0] full;
    wire  [NCFG-1:0] busy;
    wire  [NCFG-1:0] tx;

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] q3[$];
    logic [15:0] q4[$];
    longint st [NCFG][8];
    int stn [NCFG] = '{default: 0};

    function automatic void chk(input int k, input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL cfg%0d %s actual=%0d required=%0d", k, name, act, exp);
        end
    endfunction

    function automatic void q_push(input int k, input logic [15:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            3: q3.push_back(v);
            default: q4.push_back(v);
        endcase
    endfunction
    function automatic int q_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            default: return q4.size();
        endcase
    endfunction
    function automatic logic [15:0] q_pop(input int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            3: return q3.pop_front();
            default: return q4.pop_front();
        endcase
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
        localparam int      DB = c_bits(g);
        localparam parity_t PB = c_par(g);
        localparam int      R  = bit_cycles(g);
        localparam int      NB = frame_len(g);

        uart_tx_cfg #(
            .CLK_FRE    (c_clk(g)),
            .UART_RATE  (c_baud(g)),
            .DATA_BITS  (DB),
            .PARITY     (PB),
            .STOP_BITS  (c_stop(g)),
            .FIFO_DEPTH (c_depth(g))
        ) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .send_en   (en[g]),
            .send_data (sdata[g][DB-1:0]),
            .send_full (full[g]),
            .send_busy (busy[g]),
            .tx_pin    (tx[g])
        );

        // Monitor: a falling line starts a frame; every cycle of every bit is compared.
        initial begin : mon
            logic [15:0] ev;
            bit known;
            bit aborted;
            int bad_cyc;
            forever begin
                @(negedge clk);
                if (!rst[g] && tx[g] == 1'b0) begin
                    known = (q_size(g) != 0);
                    ev = known ? q_pop(g) : 16'h0;
                    if (!known) chk(g, "unexpected_frame", 1, 0);
                    if (stn[g] < 8) st[g][stn[g]] = cyc;
                    stn[g]++;
                    aborted = 1'b0;
                    for (int b = 0; b < NB && !aborted; b++) begin
                        bad_cyc = 0;
                        for (int c = 0; c < R && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst[g]) aborted = 1'b1;
                            else if (tx[g] !== ev[b]) bad_cyc++;
                        end
                        if (!aborted && known) chk(g, $sformatf("frame_bit%0d", b), bad_cyc, 0);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int k, input logic [8:0] d, input bit push);
        sdata[k] = d;
        en[k] = 1'b1;
        @(posedge clk);
        #1;
        en[k] = 1'b0;
        if (push) q_push(k, frame_of(k, d));
    endtask

    task automatic busy_time(input int k, input int limit, output int dur);
        dur = 0;
        while (busy[k] && dur < limit) begin
            @(posedge clk);
            #1;
            dur++;
        end
    endtask

    task automatic run0();
        int dur;
        int hi_bad;
        wr(0, 9'h055, 1'b1);
        chk(0, "tx_before_pop", tx[0], 1);
        chk(0, "busy_on_write", busy[0], 1);
        idle(1);
        chk(0, "tx_start_edge", tx[0], 0);
        busy_time(0, 6000, dur);
        chk(0, "busy_len", dur, frame_cycles(0));
        chk(0, "tx_idle_after", tx[0], 1);
        wr(0, 9'h0A3, 1'b1);
        idle(1 + 4 * bit_cycles(0) + 100);
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        chk(0, "rst_tx", tx[0], 1);
        chk(0, "rst_busy", busy[0], 0);
        chk(0, "rst_full", full[0], 0);
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        hi_bad = 0;
        for (int i = 0; i < 20 * bit_cycles(0); i++) begin
            @(posedge clk);
            #1;
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) hi_bad++;
        end
        chk(0, "line_high_after_rst", hi_bad, 0);
    endtask

    task automatic run1();
        int dur;
        wr(1, 9'h041, 1'b1);
        idle(1);
        chk(1, "tx_start_edge", tx[1], 0);
        busy_time(1, 6000, dur);
        chk(1, "busy_len", dur, frame_cycles(1));
    endtask

    task automatic run2();
        int dur;
        wr(2, 9'h0FF, 1'b1);
        wr(2, 9'h000, 1'b1);
        wr(2, 9'h001, 1'b1);
        busy_time(2, 3 * frame_cycles(2) + 100, dur);
        chk(2, "busy_len_3", dur, 3 * frame_cycles(2) - 1);
    endtask

    task automatic run3();
        int dur;
        wr(3, 9'h001, 1'b1);
        wr(3, 9'h002, 1'b1);
        wr(3, 9'h003, 1'b1);
        wr(3, 9'h004, 1'b1);
        chk(3, "full_at_3", full[3], 0);
        wr(3, 9'h005, 1'b1);
        chk(3, "full_at_4", full[3], 1);
        wr(3, 9'h006, 1'b0);
        chk(3, "full_after_drop", full[3], 1);
        busy_time(3, 5 * frame_cycles(3) + 100, dur);
        chk(3, "busy_len_5", dur, 5 * frame_cycles(3) - 4);
        chk(3, "frames_sent", stn[3], 5);
        for (int i = 0; i < 4; i++) chk(3, $sformatf("gap%0d", i), st[3][i + 1] - st[3][i], frame_cycles(3));
    endtask

    task automatic run4();
        longint tn;
        longint endc;
        int n;
        int f;
        f = frame_cycles(4);
        wr(4, 9'h1A5, 1'b1);
        tn = cyc;
        idle(9);
        wr(4, 9'h00F, 1'b1);
        idle(f - 10);
        wr(4, 9'h133, 1'b1);
        wr(4, 9'h0C0, 1'b1);
        wr(4, 9'h1FF, 1'b1);
        chk(4, "full_occ3", full[4], 0);
        wr(4, 9'h002, 1'b1);
        chk(4, "full_occ4", full[4], 1);
        while (cyc < tn + 1 + 6 * f) idle(1);
        chk(4, "drained_6", busy[4], 0);
        for (int it = 0; it < 16; it++) begin
            n = $urandom_range(1, 4);
            endc = 0;
            for (int j = 0; j < n; j++) begin
                wr(4, 9'($urandom_range(0, 511)), 1'b1);
                if (j == 0) endc = cyc + 1 + longint'(n * f);
                if (j != n - 1) idle($urandom_range(0, 2));
            end
            while (cyc < endc) idle(1);
            chk(4, "burst_done", busy[4], 0);
            idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = '1;
        en = '0;
        for (int k = 0; k < NCFG; k++) sdata[k] = '0;
        idle(3);
        for (int k = 0; k < NCFG; k++) begin
            chk(k, "reset_tx", tx[k], 1);
            chk(k, "reset_busy", busy[k], 0);
            chk(k, "reset_full", full[k], 0);
        end
        rst = '0;
        idle(2);
        fork
            run0();
            run1();
            run2();
            run3();
            run4();
        join
        idle(10);
        for (int k = 0; k < NCFG; k++) chk(k, "frames_left", q_size(k), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
